// File: rtl/gbc_pad_pkg.sv
// Shared constants for the NES/SNES serial pad reader: scan state codes,
// pad bit counts and default timing.
package gbc_pad_pkg;

  localparam int NES_BITS            = 8;
  localparam int SNES_BITS           = 16;
  localparam int DEFAULT_CLK_DIV     = 300;
  localparam int DEFAULT_POLL_PERIOD = 554400;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LATCH = 3'd1;
  localparam logic [2:0] ST_LOW   = 3'd2;
  localparam logic [2:0] ST_HIGH  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/pad_shift_chan.sv
// One pad's capture channel: bit-addressed shift register plus, when
// PAD_DEBOUNCE_EN is defined, the previous scan used to gate updates.
module pad_shift_chan
  import gbc_pad_pkg::*;
#(
  parameter int NUM_BITS = NES_BITS
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sample,
  input  logic [$clog2(NUM_BITS)-1:0] index,
  input  logic                        data_bit,
  input  logic                        commit,
  output logic [NUM_BITS-1:0]         shift,
  output logic                        accept
);

  always_ff @(posedge clock) begin
    if (reset) begin
      shift <= '0;
    end else if (sample) begin
      shift[index] <= data_bit;
    end
  end

`ifdef PAD_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prev;

  // A scan is only accepted when it repeats the one before it.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev <= '0;
    end else if (commit) begin
      prev <= shift;
    end
  end

  assign accept = commit && (shift == prev);
`else
  assign accept = commit;
`endif

endmodule

// File: rtl/serial_pad_reader.sv
// NES/SNES serial pad reader: periodic latch/pulse scan of up to four pads
// sharing one latch and one shift clock. Optional macro: PAD_DEBOUNCE_EN.
module serial_pad_reader
  import gbc_pad_pkg::*;
#(
  parameter int NUM_PADS    = 1,
  parameter int NUM_BITS    = NES_BITS,
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int POLL_PERIOD = DEFAULT_POLL_PERIOD
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         poll_now,
  input  logic [NUM_PADS-1:0]          data,
  output logic                         latch,
  output logic                         pulse,
  output logic [NUM_PADS*NUM_BITS-1:0] buttons,
  output logic                         valid,
  output logic                         press_irq,
  output logic                         busy
);

  localparam int TW = $clog2(2*CLK_DIV+1);
  localparam int IW = $clog2(NUM_BITS);
  localparam int PW = $clog2(POLL_PERIOD+1);
  localparam logic [TW-1:0] T_LATCH   = TW'(2*CLK_DIV-1);
  localparam logic [TW-1:0] T_HALF    = TW'(CLK_DIV-1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_BITS-1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD-1);

  if (NUM_PADS < 1 || NUM_PADS > 4 || (NUM_BITS != NES_BITS && NUM_BITS != SNES_BITS)
      || CLK_DIV < 1 || POLL_PERIOD < 1) begin : g_bad_config
    $error("serial_pad_reader: unsupported NUM_PADS/NUM_BITS/CLK_DIV/POLL_PERIOD");
  end

  logic [2:0]                   state, state_nxt;
  logic [TW-1:0]                timer, timer_nxt;
  logic [IW-1:0]                index;
  logic [PW-1:0]                poll_cnt;
  logic [NUM_PADS*NUM_BITS-1:0] shift_all, next_btn;
  logic [NUM_PADS-1:0]          accept;
  logic                         sample, commit;

  assign busy   = (state != ST_IDLE);
  assign sample = (state == ST_LOW) && (timer == '0);
  assign commit = (state == ST_DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (poll_now || poll_cnt == POLL_LAST) state_nxt = ST_LATCH;
      ST_LATCH: if (timer == '0) state_nxt = ST_LOW;
      ST_LOW:   if (timer == '0) state_nxt = ST_HIGH;
      ST_HIGH:  if (timer == '0) state_nxt = (index == IDX_LAST) ? ST_DONE : ST_LOW;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The single phase timer reloads on every state change and counts down to zero.
  always_comb begin
    timer_nxt = timer;
    if (state_nxt != state) begin
      case (state_nxt)
        ST_LATCH:        timer_nxt = T_LATCH;
        ST_LOW, ST_HIGH: timer_nxt = T_HALF;
        default:         timer_nxt = '0;
      endcase
    end else if (timer != '0) begin
      timer_nxt = timer - 1'b1;
    end
  end

  always_comb begin
    next_btn = buttons;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (accept[p]) next_btn[p*NUM_BITS +: NUM_BITS] = ~shift_all[p*NUM_BITS +: NUM_BITS];
    end
  end

  // latch/pulse come straight from flops decoded off the next state, so they never overlap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      timer     <= '0;
      index     <= '0;
      poll_cnt  <= '0;
      latch     <= 1'b0;
      pulse     <= 1'b0;
      buttons   <= '0;
      valid     <= 1'b0;
      press_irq <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      latch     <= (state_nxt == ST_LATCH);
      pulse     <= (state_nxt == ST_HIGH);
      buttons   <= next_btn;
      valid     <= |accept;
      press_irq <= |(next_btn & ~buttons);
      if (state == ST_IDLE && state_nxt == ST_LATCH) begin
        poll_cnt <= '0;
      end else if (poll_cnt != POLL_LAST) begin
        poll_cnt <= poll_cnt + 1'b1;
      end
      if (state_nxt == ST_LATCH) begin
        index <= '0;
      end else if (state == ST_HIGH && state_nxt == ST_LOW) begin
        index <= index + 1'b1;
      end
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_chan
    pad_shift_chan #(.NUM_BITS(NUM_BITS)) u_chan (
      .clock    (clock),
      .reset    (reset),
      .sample   (sample),
      .index    (index),
      .data_bit (data[p]),
      .commit   (commit),
      .shift    (shift_all[p*NUM_BITS +: NUM_BITS]),
      .accept   (accept[p])
    );
  end

endmodule

// File: tb/tb_serial_pad_reader.sv
// Randomized self-checking bench for serial_pad_reader with a behavioural
// shift-register pad model and a scan-level reference model.
module tb_serial_pad_reader;

  localparam int NUM_PADS    = 2;
  localparam int NUM_BITS    = 8;
  localparam int CLK_DIV     = 4;
  localparam int POLL_PERIOD = 100;
  localparam int SCAN_LAT    = 2*CLK_DIV + 2*NUM_BITS*CLK_DIV + 1;

  logic                         clock = 1'b0;
  logic                         reset;
  logic                         poll_now;
  logic [NUM_PADS-1:0]          data;
  logic                         latch, pulse, valid, press_irq, busy;
  logic [NUM_PADS*NUM_BITS-1:0] buttons;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Pad model: buttons snapshotted on latch, one bit advanced per pulse rise.
  logic [NUM_PADS*NUM_BITS-1:0] pad_bits = '0;
  logic [NUM_PADS*NUM_BITS-1:0] snap = '0;
  int pidx = 0;

  logic [NUM_PADS*NUM_BITS-1:0] exp_buttons = '0;
`ifdef PAD_DEBOUNCE_EN
  logic [NUM_BITS-1:0] prev_pressed [NUM_PADS];
`endif

  // Waveform monitor state, updated at every falling edge.
  int  latch_rises = 0, latch_rise_cyc = 0, latch_len = 0;
  int  pulse_rises = 0, hi_len = 0, low_len = 0, shape_bad = 0;
  int  valid_cnt = 0, valid_cyc = 0, irq_cnt = 0, scan_done = 0;
  int  overlap = 0;
  logic latch_q = 1'b0, pulse_q = 1'b0, busy_q = 1'b0;

  serial_pad_reader #(
    .NUM_PADS(NUM_PADS), .NUM_BITS(NUM_BITS), .CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL_PERIOD)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .poll_now  (poll_now),
    .data      (data),
    .latch     (latch),
    .pulse     (pulse),
    .buttons   (buttons),
    .valid     (valid),
    .press_irq (press_irq),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  always @(posedge latch) begin
    snap = pad_bits;
    pidx = 0;
  end
  always @(posedge pulse) pidx++;

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      data[p] = (pidx < NUM_BITS) ? ~snap[p*NUM_BITS + pidx] : 1'b1;
    end
  end

  always @(negedge clock) begin
    if (latch && !latch_q) begin
      latch_rises++;
      latch_rise_cyc = cyc;
      latch_len = 0;
      pulse_rises = 0;
      shape_bad = 0;
      low_len = 0;
    end
    if (latch) latch_len++;
    if (latch && pulse) overlap = 1;
    if (pulse && !pulse_q) begin
      pulse_rises++;
      if (low_len != CLK_DIV) shape_bad++;
      low_len = 0;
      hi_len = 0;
    end
    if (pulse) hi_len++;
    if (!pulse && pulse_q && hi_len != CLK_DIV) shape_bad++;
    if (busy && !latch && !pulse) low_len++;
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (press_irq) irq_cnt++;
    if (!busy && busy_q) scan_done++;
    latch_q = latch;
    pulse_q = pulse;
    busy_q  = busy;
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic resetModel();
    exp_buttons = '0;
`ifdef PAD_DEBOUNCE_EN
    for (int p = 0; p < NUM_PADS; p++) prev_pressed[p] = '1;
`endif
  endtask

  // Expected outcome of one completed scan, computed from the pressed pattern.
  task automatic modelScan(input logic [NUM_PADS*NUM_BITS-1:0] pressed,
                           output int exp_valid, output int exp_irq);
    logic [NUM_BITS-1:0] pn;
    bit upd;
    exp_valid = 0;
    exp_irq = 0;
    for (int p = 0; p < NUM_PADS; p++) begin
      pn = pressed[p*NUM_BITS +: NUM_BITS];
`ifdef PAD_DEBOUNCE_EN
      upd = (pn == prev_pressed[p]);
      prev_pressed[p] = pn;
`else
      upd = 1'b1;
`endif
      if (upd) begin
        exp_valid = 1;
        if ((pn & ~exp_buttons[p*NUM_BITS +: NUM_BITS]) != '0) exp_irq = 1;
        exp_buttons[p*NUM_BITS +: NUM_BITS] = pn;
      end
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_latch"}, 32'(latch), 0);
    checkOutput({tag, "_pulse"}, 32'(pulse), 0);
    checkOutput({tag, "_buttons"}, 32'(buttons), 0);
    checkOutput({tag, "_valid"}, 32'(valid), 0);
    checkOutput({tag, "_irq"}, 32'(press_irq), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Runs one scan (started by poll_now or by the poll timer) and checks it.
  task automatic applyStimulus(input logic [NUM_PADS*NUM_BITS-1:0] pressed, input bit use_poll,
                               input int natural_latch, input bit poke_busy);
    int v0, i0, d0, l0, budget, exp_latch, exp_valid, exp_irq;
    bit poked;
    pad_bits = pressed;
    v0 = valid_cnt; i0 = irq_cnt; d0 = scan_done; l0 = latch_rises;
    exp_latch = natural_latch;
    if (use_poll) begin
      exp_latch = cyc + 1;
      poll_now = 1'b1;
      tick();
      poll_now = 1'b0;
    end
    poked = 0;
    budget = 0;
    while (scan_done == d0 && budget < 400) begin
      if (poke_busy && !poked && busy && !latch && !pulse && latch_rises != l0
          && pulse_rises >= 1 && pulse_rises < 4) begin
        poll_now = 1'b1;
        tick();
        poll_now = 1'b0;
        poked = 1;
      end else begin
        tick();
      end
      budget++;
    end
    if (scan_done == d0) begin
      checkOutput("scan_timeout", 0, 1);
      return;
    end
    modelScan(pressed, exp_valid, exp_irq);
    checkOutput("latch_rise_cycle", 32'(latch_rise_cyc), 32'(exp_latch));
    checkOutput("latch_width", 32'(latch_len), 2*CLK_DIV);
    checkOutput("pulse_count", 32'(pulse_rises), NUM_BITS);
    checkOutput("pulse_shape", 32'(shape_bad), 0);
    checkOutput("valid_count", 32'(valid_cnt - v0), 32'(exp_valid));
    checkOutput("irq_count", 32'(irq_cnt - i0), 32'(exp_irq));
    if (exp_valid != 0) checkOutput("latency", 32'(valid_cyc - latch_rise_cyc), SCAN_LAT);
    checkOutput("buttons", 32'(buttons), 32'(exp_buttons));
  endtask

  initial begin
    int rel, l0, v0, budget, last_latch;
    reset = 1'b1;
    poll_now = 1'b0;
    resetModel();
    repeat (3) tick();
    checkResetOutputs("por");
    reset = 1'b0;
    rel = cyc;

    $display("[TB] first timed scan, all released");
    applyStimulus(16'h0000, 0, rel + POLL_PERIOD, 0);

    $display("[TB] directed press patterns");
    applyStimulus(16'h8009, 1, 0, 0);
    applyStimulus(16'h8009, 1, 0, 0);
    applyStimulus(16'h8001, 1, 0, 0);

    $display("[TB] poll_now while busy, then timer-driven scan");
    applyStimulus(16'h0101, 1, 0, 1);
    last_latch = latch_rise_cyc;
    l0 = latch_rises;
    repeat (20) tick();
    checkOutput("poll_ignored", 32'(latch_rises - l0), 0);
    applyStimulus(16'h0202, 0, last_latch + POLL_PERIOD, 0);

    $display("[TB] random scans");
    for (int i = 0; i < 6; i++) begin
      logic [NUM_PADS*NUM_BITS-1:0] rnd;
      rnd = (NUM_PADS*NUM_BITS)'($urandom);
      applyStimulus(rnd, 1, 0, 0);
      if (i % 2 == 1) applyStimulus(rnd, 1, 0, 0);
    end
    applyStimulus(16'h00F0, 1, 0, 0);
    applyStimulus(16'h00F0, 1, 0, 0);

    $display("[TB] reset during HIGH of bit 4");
    pad_bits = 16'h3C3C;
    poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    budget = 0;
    while (!(pulse_rises >= 5 && pulse && busy) && budget < 200) begin
      tick();
      budget++;
    end
    if (budget >= 200) checkOutput("abort_point_timeout", 0, 1);
    reset = 1'b1;
    tick();
    checkResetOutputs("abort");
    v0 = valid_cnt;
    reset = 1'b0;
    resetModel();
    repeat (9) tick();
    checkOutput("no_valid_after_abort", 32'(valid_cnt - v0), 0);
    applyStimulus(16'h0180, 1, 0, 0);
    applyStimulus(16'h0180, 1, 0, 0);

    checkOutput("latch_pulse_overlap", 32'(overlap), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_pad_reader.md
SERIAL_PAD_READER -- requirements
Module: serial_pad_reader

Interface
REQ-001 SHALL have parameter NUM_PADS, default 1: number of serial pads sharing latch/pulse, legal 1..4.
REQ-002 SHALL have parameter NUM_BITS, default 8: bits per pad per scan; 8 = NES, 16 = SNES.
REQ-003 SHALL have parameter CLK_DIV, default 300: clock cycles per pulse half-period, legal >= 1.
REQ-004 SHALL have parameter POLL_PERIOD, default 554400: cycles from one scan start (latch rise) to the next.
REQ-005 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port poll_now, input, 1: request an immediate scan.
REQ-008 SHALL have port data, input, NUM_PADS: serial data from each pad, active-low button bits.
REQ-009 SHALL have port latch, output, 1: pad latch, shared by all pads.
REQ-010 SHALL have port pulse, output, 1: pad shift clock, shared by all pads.
REQ-011 SHALL have port buttons, output, NUM_PADS*NUM_BITS: active-high button state; pad p at bits [p*NUM_BITS +: NUM_BITS]; bit 0 is the first bit shifted.
REQ-012 SHALL have port valid, output, 1: one-cycle strobe on each buttons update.
REQ-013 SHALL have port press_irq, output, 1: one-cycle strobe when any button goes from 0 to 1 in that update.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, LATCH, LOW, HIGH, DONE.
REQ-016 IDLE -> LATCH when the poll counter reaches POLL_PERIOD-1, or when poll_now=1; the poll counter clears on LATCH entry.
REQ-017 LATCH SHALL drive latch=1 and pulse=0 for 2*CLK_DIV cycles, then enter LOW with bit index 0.
REQ-018 LOW SHALL drive pulse=0 for CLK_DIV cycles and sample data[p] into shift bit [index] of each pad on its last cycle; it then enters HIGH.
REQ-019 HIGH SHALL drive pulse=1 for CLK_DIV cycles; on exit the block increments index and enters LOW, or enters DONE when index = NUM_BITS-1.
REQ-020 DONE SHALL last 1 cycle; the block sets buttons to the inverted shift data and asserts valid.
REQ-021 In the DONE cycle, the block asserts press_irq iff (new & ~old) is nonzero across all pads. It then enters IDLE.
REQ-022 A scan SHALL take 2*CLK_DIV + 2*NUM_BITS*CLK_DIV + 1 cycles (latency, latch rise to valid).
REQ-023 poll_now while busy=1 SHALL be ignored and not queued.
REQ-024 If the poll counter expires during a scan, the next scan SHALL start in the cycle after DONE.
REQ-025 The poll counter SHALL saturate at POLL_PERIOD-1 and never wrap.
REQ-026 latch and pulse SHALL be registered outputs, glitch-free, and never high together.
REQ-027 A single down-counter SHALL time all phases; its width is $clog2(2*CLK_DIV+1).

Reset
REQ-028 reset SHALL force IDLE with latch=0, pulse=0, buttons=0, valid=0, press_irq=0, busy=0, index=0, poll counter=0, and shift register=0, all in the next cycle.
REQ-029 reset mid-scan SHALL abort the scan; buttons keep no partial data, and no valid is produced.
REQ-030 The first scan after reset SHALL start POLL_PERIOD cycles after reset deasserts, unless poll_now arrives first.

Configuration
REQ-031 Macro PAD_DEBOUNCE_EN defined: a pad's buttons update only when two consecutive scans of that pad return identical data.
REQ-032 With PAD_DEBOUNCE_EN defined, valid and press_irq fire only when at least one pad updated.
REQ-033 PAD_DEBOUNCE_EN undefined: every scan updates buttons and asserts valid, and the block has no previous-scan storage.

Structure
REQ-034 Package gbc_pad_pkg SHALL hold the state enum, NES_BITS=8, SNES_BITS=16, and default CLK_DIV/POLL_PERIOD constants.
REQ-035 The block SHALL have one sub-module, pad_shift_chan: a per-pad shift register plus debounce storage, instantiated NUM_PADS times.
REQ-036 Elaboration SHALL fail when NUM_PADS is outside 1..4 or NUM_BITS is not 8 or 16.

Verification (NUM_PADS=2, NUM_BITS=8, CLK_DIV=4, POLL_PERIOD=100 unless stated)
REQ-037 Scenario: reset release, data=2'b11 -> latch rises at cycle 100 and stays high 8 cycles; 8 pulses of 4 low/4 high follow; valid at latch-rise+73; buttons=16'h0000; press_irq=0.
REQ-038 Scenario: pad0 drives 0 for bits 0 and 3, pad1 drives 0 for bit 7 -> buttons=16'h8009, valid=1, press_irq=1.
REQ-039 Scenario: same data on the next scan -> buttons=16'h8009, valid=1, press_irq=0; release bit 3 -> buttons=16'h8001, press_irq=0.
REQ-040 Scenario: poll_now at cycle 10 after reset -> latch at cycle 11; poll_now during the LOW state is ignored; POLL_PERIOD=50 -> back-to-back scans 74 cycles apart.
REQ-041 Scenario: reset asserted during HIGH of bit 4 -> next cycle all outputs zero, no valid pulse.
REQ-042 Scenario: PAD_DEBOUNCE_EN defined, bit toggles on alternate scans -> buttons unchanged and no valid; two matching scans -> update and valid.
